// File: rtl/btn_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM encoding and helpers.
package btn_pkg;

  localparam int BTN_STATE_W = 2;

  typedef enum logic [BTN_STATE_W-1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  function automatic int btn_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: tick-qualified FSM, saturating stability counter, level/pulse outputs.
// Optional auto-repeat of the press pulse when BTN_DEBOUNCE_AUTO_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int STABLE_CNT    = 4,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic s_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  btn_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d;
  logic press_q, press_d;
  logic release_q, release_d;
  logic rep_fire;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_TOP) ? CNT_TOP : v + CNT_ONE;
  endfunction

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
  localparam int REP_W = $clog2(btn_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
  logic rep_ph_q, rep_ph_d;
`else
  localparam int unused_rep_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
      rep_q     <= '0;
      rep_ph_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
      rep_q     <= rep_d;
      rep_ph_q  <= rep_ph_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (tick_i) begin
      case (state_q)
        ST_IDLE: begin
          if (s_i) begin
            if (STABLE_CNT == 1) begin
              state_d = ST_PRESSED;
            end else begin
              state_d = ST_PRESS_WAIT;
              cnt_d   = CNT_ONE;
            end
          end
        end
        ST_PRESS_WAIT: begin
          if (!s_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_sat_inc(cnt_q) >= CNT_TOP) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_sat_inc(cnt_q);
          end
        end
        ST_PRESSED: begin
          if (!s_i) begin
            if (STABLE_CNT == 1) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RELEASE_WAIT;
              cnt_d   = CNT_ONE;
            end
          end
        end
        default: begin
          // A bounce back to 1 during release returns to PRESSED without a new press pulse
          if (s_i) begin
            state_d = ST_PRESSED;
            cnt_d   = '0;
          end else if (cnt_sat_inc(cnt_q) >= CNT_TOP) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_sat_inc(cnt_q);
          end
        end
      endcase
    end
  end

`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
  // Repeat counter only runs while PRESSED persists; entry or exit restarts the delay phase
  always_comb begin
    rep_d    = rep_q;
    rep_ph_d = rep_ph_q;
    rep_fire = 1'b0;
    rep_inc  = rep_q + REP_W'(1);
    if ((state_q != ST_PRESSED) || (state_d != ST_PRESSED)) begin
      rep_d    = '0;
      rep_ph_d = 1'b0;
    end else if (tick_i) begin
      if (rep_inc == (rep_ph_q ? REP_W'(REPEAT_PERIOD) : REP_W'(REPEAT_DELAY))) begin
        rep_fire = 1'b1;
        rep_d    = '0;
        rep_ph_d = 1'b1;
      end else begin
        rep_d    = rep_inc;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    level_d   = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    press_d   = (level_d & ~level_q) | rep_fire;
    release_d = ~level_d & level_q;
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_debounce.sv
// N_BTN-channel button debouncer clocked by a rising-edge tick of clkdiv[TICK_BIT].
// Build option: define BTN_DEBOUNCE_AUTO_REPEAT_EN for auto-repeating press pulses.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int TICK_BIT      = 17,
  parameter int STABLE_CNT    = 4,
  parameter int ACTIVE_LOW    = 0,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      clkdiv,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  logic             prev_q;
  logic             tick;
  logic [N_BTN-1:0] raw;
  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic             unused_clkdiv;

  assign unused_clkdiv = ^clkdiv;
  assign raw  = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;
  assign tick = clkdiv[TICK_BIT] & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      prev_q  <= clkdiv[TICK_BIT];
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CNT   (STABLE_CNT),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .tick_i   (tick),
      .s_i      (sync2_q[gi]),
      .level_o  (btn_level[gi]),
      .press_o  (btn_press[gi]),
      .release_o(btn_release[gi])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: tick every 8 clk, 4-sample debounce, 4 buttons.
module tb_btn_debounce;

  localparam int N_BTN = 4;
`ifdef BTN_DEBOUNCE_AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      clkdiv;
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level, btn_press, btn_release;

  int n_vec = 0;
  int n_err = 0;

  btn_debounce #(
    .N_BTN(N_BTN), .TICK_BIT(2), .STABLE_CNT(4), .ACTIVE_LOW(0),
    .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .rst(rst), .clkdiv(clkdiv), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  initial begin
    clkdiv = 32'd0;
    forever begin
      @(negedge clk);
      clkdiv = clkdiv + 32'd1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Returns 1 ns after the clock edge at which the FSMs consume a tick.
  task automatic next_tick();
    do begin
      @(negedge clk);
      #1;
    end while (clkdiv[2:0] != 3'd4);
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    do begin
      @(negedge clk);
      #1;
    end while (clkdiv[2:0] != 3'd1);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check_vec({tag, "_level"},   32'(btn_level),   32'h0);
    check_vec({tag, "_press"},   32'(btn_press),   32'h0);
    check_vec({tag, "_release"}, 32'(btn_release), 32'h0);
  endtask

  initial begin
    logic exp_p;
    rst    = 1'b1;
    btn_in = 4'hF;

    // 1: outputs stay 0 while reset is held, regardless of inputs
    #1;
    check_idle("rst_t0");
    for (int i = 0; i < 4; i++) begin
      repeat (5) @(posedge clk);
      #1;
      check_idle("rst_held");
    end
    btn_in = 4'h0;
    release_rst();
    next_tick();
    check_idle("post_rst");

    // 2: clean press on bit 0
    btn_in[0] = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      next_tick();
      check_vec("press0_wait_level", 32'(btn_level), 32'h0);
      check_vec("press0_wait_press", 32'(btn_press), 32'h0);
    end
    next_tick();
    check_vec("press0_level", 32'(btn_level), 32'h1);
    check_vec("press0_press", 32'(btn_press), 32'h1);
    @(posedge clk);
    #1;
    check_vec("press0_pulse_end", 32'(btn_press), 32'h0);
    check_vec("press0_level_hold", 32'(btn_level), 32'h1);
    for (int t = 5; t <= 10; t++) begin
      next_tick();
      check_vec("press0_held_level", 32'(btn_level), 32'h1);
      check_vec("press0_held_press", 32'(btn_press), 32'h0);
    end

    // 4: release bit 0
    btn_in[0] = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      next_tick();
      check_vec("rel0_wait_level", 32'(btn_level), 32'h1);
      check_vec("rel0_wait_release", 32'(btn_release), 32'h0);
    end
    next_tick();
    check_vec("rel0_level", 32'(btn_level), 32'h0);
    check_vec("rel0_release", 32'(btn_release), 32'h1);
    @(posedge clk);
    #1;
    check_vec("rel0_pulse_end", 32'(btn_release), 32'h0);

    // 3: bit 1 bouncing every tick never qualifies
    for (int t = 1; t <= 12; t++) begin
      btn_in[1] = ~btn_in[1];
      next_tick();
      check_idle("bounce1");
    end

    // 5: reset in the middle of a press wait discards the partial count
    btn_in[2] = 1'b1;
    next_tick();
    next_tick();
    check_idle("pw2_before_rst");
    rst = 1'b1;
    #1;
    check_idle("pw2_in_rst");
    release_rst();
    for (int t = 1; t <= 3; t++) begin
      next_tick();
      check_vec("pw2_after_rst_level", 32'(btn_level), 32'h0);
      check_vec("pw2_after_rst_press", 32'(btn_press), 32'h0);
    end
    next_tick();
    check_vec("pw2_level", 32'(btn_level), 32'h4);
    check_vec("pw2_press", 32'(btn_press), 32'h4);
    btn_in[2] = 1'b0;
    for (int t = 1; t <= 5; t++) next_tick();
    check_vec("pw2_released", 32'(btn_level), 32'h0);

    // 6: bit 3 held 25 ticks; repeats only in the auto-repeat build
    btn_in[3] = 1'b1;
    for (int t = 1; t <= 25; t++) begin
      next_tick();
      exp_p = (t == 4) || (REP_EN && t >= 12 && ((t - 12) % 3) == 0);
      check_vec($sformatf("hold3_press_t%0d", t), 32'(btn_press), {28'h0, exp_p, 3'b000});
      check_vec($sformatf("hold3_level_t%0d", t), 32'(btn_level), (t >= 4) ? 32'h8 : 32'h0);
      @(posedge clk);
      #1;
      check_vec($sformatf("hold3_pulse_end_t%0d", t), 32'(btn_press), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
